// File: rtl/sseg_scan_driver.sv
// Four-digit multiplexed seven-segment driver: hex display or decimal via a sequential double-dabble converter.
// Optional leading-zero blanking in decimal mode is compiled in with `define SSEG_LZ_BLANK_EN.
module sseg_scan_driver #(
    parameter int SYNC_STAGES = 2,
    parameter bit ACTIVE_LOW  = 1'b1
) (
    input  logic        clockin,
    input  logic        reset,
    input  logic        scan_clk,
    input  logic [15:0] data_in,
    input  logic        data_valid,
    input  logic        hex_mode,
    output logic        busy,
    output logic [3:0]  anodes,
    output logic [7:0]  cathodes
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SHIFT  = 2'd1;
    localparam logic [1:0] ST_COMMIT = 2'd2;

    localparam logic [3:0] AN_OFF = ACTIVE_LOW ? 4'hF : 4'h0;
    localparam logic [7:0] CA_OFF = ACTIVE_LOW ? 8'hFF : 8'h00;

    function automatic logic [6:0] seg_lut(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0: s = 7'h3F;  4'h1: s = 7'h06;  4'h2: s = 7'h5B;  4'h3: s = 7'h4F;
            4'h4: s = 7'h66;  4'h5: s = 7'h6D;  4'h6: s = 7'h7D;  4'h7: s = 7'h07;
            4'h8: s = 7'h7F;  4'h9: s = 7'h6F;  4'hA: s = 7'h77;  4'hB: s = 7'h7C;
            4'hC: s = 7'h39;  4'hD: s = 7'h5E;  4'hE: s = 7'h79;  default: s = 7'h71;
        endcase
        return s;
    endfunction

    function automatic logic [3:0] add3_digit(input logic [3:0] d);
        return (d >= 4'd5) ? d + 4'd3 : d;
    endfunction

    logic [SYNC_STAGES-1:0] sync_p0;
    logic                   scan_last_p1;
    logic                   scan_edge;
    logic [1:0]             idx_q;

    logic [1:0]  state_q;
    logic [3:0]  cnt_q;
    logic [15:0] bin_q;
    logic [19:0] bcd_q;
    logic [19:0] bcd_adj;

    logic [3:0][3:0] digit_q;
    logic            dash_q;
    logic [3:0]      blank_q;

    logic [6:0] cur_seg;
    logic       cur_lit;
    logic [3:0] an_hi;
    logic [7:0] ca_hi;

    // Scan strobe: synchroniser chain, then rising-edge detect on the last stage
    assign scan_edge = sync_p0[SYNC_STAGES-1] & ~scan_last_p1;

    always_ff @(posedge clockin or posedge reset) begin
        if (reset) begin
            sync_p0      <= '0;
            scan_last_p1 <= 1'b0;
            idx_q        <= 2'd0;
        end else begin
            sync_p0      <= {sync_p0[SYNC_STAGES-2:0], scan_clk};
            scan_last_p1 <= sync_p0[SYNC_STAGES-1];
            if (scan_edge) idx_q <= idx_q + 2'd1;
        end
    end

    always_comb begin
        bcd_adj = '0;
        for (int i = 0; i < 5; i++) bcd_adj[4*i +: 4] = add3_digit(bcd_q[4*i +: 4]);
    end

    assign busy = (state_q != ST_IDLE);

    always_ff @(posedge clockin or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (data_valid && !hex_mode) begin
                        state_q <= ST_SHIFT;
                        cnt_q   <= 4'd0;
                    end
                end
                ST_SHIFT: begin
                    cnt_q <= cnt_q + 4'd1;
                    if (cnt_q == 4'd15) state_q <= ST_COMMIT;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Converter datapath carries no reset; it is cleared on every decimal load
    always_ff @(posedge clockin) begin
        if (state_q == ST_IDLE && data_valid && !hex_mode) begin
            bin_q <= data_in;
            bcd_q <= 20'd0;
        end else if (state_q == ST_SHIFT) begin
            {bcd_q, bin_q} <= {bcd_adj, bin_q} << 1;
        end
    end

    always_ff @(posedge clockin or posedge reset) begin
        if (reset) begin
            digit_q <= '0;
            dash_q  <= 1'b0;
            blank_q <= 4'b0;
        end else if (state_q == ST_IDLE && data_valid && hex_mode) begin
            digit_q <= data_in;
            dash_q  <= 1'b0;
            blank_q <= 4'b0;
        end else if (state_q == ST_COMMIT) begin
            if (bcd_q[19:16] != 4'd0) begin
                dash_q  <= 1'b1;
                blank_q <= 4'b0;
            end else begin
                digit_q <= bcd_q[15:0];
                dash_q  <= 1'b0;
`ifdef SSEG_LZ_BLANK_EN
                blank_q <= {bcd_q[15:12] == 4'd0, bcd_q[15:8] == 8'd0, bcd_q[15:4] == 12'd0, 1'b0};
`else
                blank_q <= 4'b0;
`endif
            end
        end
    end

    // Output stage: registered digit select and segment decode
    always_comb begin
        cur_seg = dash_q ? 7'h40 : seg_lut(digit_q[idx_q]);
        cur_lit = ~blank_q[idx_q];
        an_hi   = cur_lit ? (4'd1 << idx_q) : 4'd0;
        ca_hi   = cur_lit ? {1'b0, cur_seg} : 8'h00;
    end

    always_ff @(posedge clockin or posedge reset) begin
        if (reset) begin
            anodes   <= AN_OFF;
            cathodes <= CA_OFF;
        end else begin
            anodes   <= ACTIVE_LOW ? ~an_hi : an_hi;
            cathodes <= ACTIVE_LOW ? ~ca_hi : ca_hi;
        end
    end

endmodule

// File: tb/tb_sseg_scan_driver.sv
// Scoreboard bench for sseg_scan_driver: a display-level model predicts every cycle's outputs.
module tb_sseg_scan_driver;

    localparam int SYNC = 2;

    logic        clockin = 1'b0;
    logic        reset = 1'b0;
    logic        scan_clk = 1'b0;
    logic [15:0] data_in = 16'd0;
    logic        data_valid = 1'b0;
    logic        hex_mode = 1'b0;
    logic        busy;
    logic [3:0]  anodes;
    logic [7:0]  cathodes;

    sseg_scan_driver #(.SYNC_STAGES(SYNC), .ACTIVE_LOW(1'b1)) dut (
        .clockin(clockin), .reset(reset), .scan_clk(scan_clk),
        .data_in(data_in), .data_valid(data_valid), .hex_mode(hex_mode),
        .busy(busy), .anodes(anodes), .cathodes(cathodes)
    );

    always #5 clockin = ~clockin;

    typedef struct packed {
        logic [3:0] an;
        logic [7:0] ca;
        logic       bsy;
        logic       blk;
    } exp_t;

    exp_t exp_q[$];
    int checks = 0;
    int errors = 0;

    // Display-level model: digit codes 0..15 are hex values, 16 is a dash
    int         cyc = 0;
    int         dec_start = -1000;
    int         m_idx = 0;
    logic [19:0] m_codes = '0;
    logic [3:0]  m_blank = '0;
    int          idx_at[$];
    int          upd_at[$];
    logic [19:0] upd_codes[$];
    logic [3:0]  upd_blank[$];

    function automatic logic [6:0] seg_of(input logic [4:0] c);
        case (c)
            5'd0: return 7'h3F;  5'd1: return 7'h06;  5'd2: return 7'h5B;  5'd3: return 7'h4F;
            5'd4: return 7'h66;  5'd5: return 7'h6D;  5'd6: return 7'h7D;  5'd7: return 7'h07;
            5'd8: return 7'h7F;  5'd9: return 7'h6F;  5'd10: return 7'h77; 5'd11: return 7'h7C;
            5'd12: return 7'h39; 5'd13: return 7'h5E; 5'd14: return 7'h79; 5'd15: return 7'h71;
            default: return 7'h40;
        endcase
    endfunction

    function automatic bit busy_after(input int c);
        return (c >= dec_start) && (c <= dec_start + 16);
    endfunction

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s at t=%0t: got %h expected %h", nm, $time, act, req);
        end
    endtask

    always @(negedge clockin) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("anodes", {4'h0, anodes}, {4'h0, e.an});
            if (!e.blk) chk("cathodes", cathodes, e.ca);
            chk("busy", {7'd0, busy}, {7'd0, e.bsy});
        end
    end

    task automatic step(input bit dv, input bit hm, input logic [15:0] din, input bit sc);
        logic [19:0] codes;
        logic [3:0]  blk;
        exp_t        e;
        if (dv && !busy_after(cyc)) begin
            if (hm) begin
                for (int i = 0; i < 4; i++) codes[5*i +: 5] = {1'b0, din[4*i +: 4]};
                upd_at.push_back(cyc + 1);
                upd_codes.push_back(codes);
                upd_blank.push_back(4'b0);
            end else begin
                int v = int'(din);
                int div = 1;
                blk = 4'b0;
                if (v > 9999) begin
                    codes = {4{5'd16}};
                end else begin
                    for (int i = 0; i < 4; i++) begin
                        codes[5*i +: 5] = 5'((v / div) % 10);
                        div = div * 10;
                    end
`ifdef SSEG_LZ_BLANK_EN
                    blk = {v < 1000, v < 100, v < 10, 1'b0};
`endif
                end
                dec_start = cyc + 1;
                upd_at.push_back(cyc + 18);
                upd_codes.push_back(codes);
                upd_blank.push_back(blk);
            end
        end
        if (sc && !scan_clk) idx_at.push_back(cyc + 1 + SYNC);
        data_valid = dv;
        hex_mode   = hm;
        data_in    = din;
        scan_clk   = sc;
        @(posedge clockin);
        cyc++;
        // Registered outputs reflect the display state as it stood before this edge
        e.blk = m_blank[m_idx];
        e.an  = e.blk ? 4'hF : ~(4'd1 << m_idx);
        e.ca  = ~{1'b0, seg_of(m_codes[5*m_idx +: 5])};
        e.bsy = busy_after(cyc);
        exp_q.push_back(e);
        while (idx_at.size() > 0 && idx_at[0] == cyc) begin
            void'(idx_at.pop_front());
            m_idx = (m_idx + 1) % 4;
        end
        if (upd_at.size() > 0 && upd_at[0] == cyc) begin
            void'(upd_at.pop_front());
            m_codes = upd_codes.pop_front();
            m_blank = upd_blank.pop_front();
        end
        #1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            bit s;
            s = scan_clk;
            if ($urandom_range(1, 0) == 1) s = ~s;
            step(1'b0, 1'($urandom_range(1, 0)), 16'($urandom), s);
        end
    endtask

    task automatic do_reset();
        data_valid = 1'b0;
        scan_clk   = 1'b0;
        @(posedge clockin);
        #3 reset = 1'b1;
        #1;
        chk("reset_anodes", {4'h0, anodes}, 8'h0F);
        chk("reset_cathodes", cathodes, 8'hFF);
        chk("reset_busy", {7'd0, busy}, 8'h00);
        repeat (2) @(posedge clockin);
        #2 reset = 1'b0;
        cyc = 0;
        dec_start = -1000;
        m_idx = 0;
        m_codes = '0;
        m_blank = '0;
        idx_at.delete();
        upd_at.delete();
        upd_codes.delete();
        upd_blank.delete();
        exp_q.delete();
    endtask

    task automatic load(input logic [15:0] din, input bit hm);
        step(1'b1, hm, din, scan_clk);
        run(4);
        step(1'b1, 1'($urandom_range(1, 0)), 16'($urandom), scan_clk);
        run(70);
    endtask

    logic [15:0] dir_val [8] = '{16'hBEEF, 16'd1234, 16'd10000, 16'd42, 16'd0, 16'd9999, 16'd65535, 16'h00A0};
    bit          dir_hex [8] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

    initial begin
        do_reset();
        run(10);
        for (int k = 0; k < 8; k++) load(dir_val[k], dir_hex[k]);
        // Reset in the middle of a conversion leaves the display at its reset value
        step(1'b1, 1'b0, 16'd1234, scan_clk);
        run(5);
        do_reset();
        run(40);
        for (int k = 0; k < 40; k++) begin
            step(1'b1, 1'($urandom_range(1, 0)), 16'($urandom_range(20000, 0)), scan_clk);
            run(int'($urandom_range(30, 5)));
        end
        repeat (2) @(negedge clockin);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sseg_scan_driver.md
Name: sseg_scan_driver

Overview:
- Four-digit multiplexed seven-segment display driver, directly downstream of the 2^n clock divider.
- Consumes the divider's slow output as a scan strobe, synchronised into the system clock domain; does not use it as a clock.
- Displays a 16-bit value in hex, or in decimal via a sequential double-dabble converter.
- Sits on the peripheral bus side of the multi-cycle core.

Parameters:
SYNC_STAGES, 2, number of flops synchronising scan_clk (min 2)
ACTIVE_LOW, 1, 1 = anodes/cathodes active-low (board default); 0 = active-high

Ports:
clockin  input  1  system clock; all logic on posedge
reset  input  1  asynchronous, active-high reset
scan_clk  input  1  divided clock from the 2^n divider; treated as asynchronous data
data_in  input  16  value to display
data_valid  input  1  load strobe; single-cycle pulse
hex_mode  input  1  sampled with data_valid: 1 = hex, 0 = decimal
busy  output  1  decimal conversion in progress
anodes  output  4  digit enables, bit 0 = rightmost digit
cathodes  output  8  bits 6..0 = g f e d c b a; bit 7 = dp

Behaviour:
- Reset is asynchronous, active-high.
  - Digit index = 0, display nibbles = 0, blank flags = 0, busy = 0, converter idle.
  - anodes all inactive (4'hF when ACTIVE_LOW); cathodes all off (8'hFF when ACTIVE_LOW).
  - Assertion mid-conversion aborts it; the display is not updated.
- Scan path:
  - scan_clk passes through the SYNC_STAGES flop chain, then a rising-edge detect on the last stage.
  - Each detected edge advances the index 0->1->2->3->0.
  - Latency from a scan_clk rise to the index change is SYNC_STAGES+1 clocks.
- Outputs are registered and recomputed every cycle from the index, nibbles and blank flags.
  - Exactly one anode is active, for the current index, unless that digit is blanked; then all anodes are inactive.
  - dp is always off.
- Segment patterns, active-high view:
  - 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71 dash=40.
  - With ACTIVE_LOW the output is the bitwise inverse; e.g. '0' -> 8'hC0.
- FSM states: IDLE, SHIFT, COMMIT.
  - IDLE:
    - data_valid && hex_mode: load nibbles from data_in[15:0] on the next edge, clear blank flags, stay IDLE, busy stays 0.
    - data_valid && !hex_mode: latch data_in, clear the 20-bit BCD accumulator, shift count = 0, go to SHIFT, busy = 1.
  - SHIFT: one double-dabble iteration per clock.
    - Add 3 to every BCD nibble >= 5.
    - Shift {bcd, bin} left 1.
    - After 16 iterations go to COMMIT.
  - COMMIT:
    - If BCD digit 4 != 0 (value > 9999), all four nibbles show dash.
    - Otherwise load the low four BCD digits.
    - Go to IDLE, busy = 0.
  - busy is high for exactly 17 cycles: 16 SHIFT + 1 COMMIT.
  - The display updates atomically at COMMIT; the previous value is shown throughout.
- data_valid while busy = 1 is ignored and not queued.
- data_valid and a scan edge in the same cycle are both processed independently.
- The index is not reset by data loads.

Optional Feature:
- Macro: SSEG_LZ_BLANK_EN.
- Defined: in decimal mode, COMMIT sets blank flags on leading-zero digits 3..1.
  - Digit 0 is never blanked.
  - Hex mode and dash display never blank.
- Undefined: blank flags stay 0; all four digits are always driven.

Test Plan:
- Reset: assert reset asynchronously mid-cycle -> anodes = 4'hF and cathodes = 8'hFF immediately. One clock after release: anodes = 4'hE, cathodes = 8'hC0.
- Hex load: data_in = 16'hBEEF, hex_mode = 1, data_valid pulse -> busy stays 0. Stepping four scan edges gives digits 0..3 = F, E, E, b, i.e. cathodes 8'h8E, 8'h86, 8'h86, 8'h83.
- Decimal: data_in = 1234, hex_mode = 0 -> busy high for exactly 17 cycles; nibbles then read 4, 3, 2, 1. A second data_valid during busy has no effect.
- Overflow: data_in = 10000 decimal -> after COMMIT all digits show cathodes 8'hBF.
- Scan timing: toggle scan_clk with SYNC_STAGES = 2 -> index advances 3 clocks after each rising edge, nothing on falling edges, wraps 3 -> 0 (anodes 4'h7 -> 4'hE).
- Optional feature: data_in = 42 decimal, with SSEG_LZ_BLANK_EN defined -> digits 3 and 2 drive anodes = 4'hF in their slots, and digit 0 (value 2) remains lit. Without the macro, digits show 0, 0, 4, 2.
